// File: rtl/cond_flag_unit.sv
// Condition/flag stage behind the ALU: stores {N,Z,C,V}, evaluates the condition field and gates the write strobes.
// Optional feature: define STICKY_OVF_EN to add a sticky overflow bit cleared by sticky_clr.
module cond_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       sticky_clr,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       sticky_ovf
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       commit;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Decode uses the stored flags only; a flag-setting instruction sees the pre-update values.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      default: cond_ex = 1'b1;
    endcase
  end

  assign commit   = en & cond_ex;
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & commit;
  assign RegWrite = RegW & commit;
  assign MemWrite = MemW & commit;
  assign Flags    = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (commit && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
    if (commit && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= RESET_FLAGS;
    else        flags_q <= flags_d;
  end

`ifdef STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Clear is a state change, so it is also frozen by a stall; a new set beats a clear.
  always_comb begin
    sticky_d = sticky_q;
    if (en) sticky_d = (commit & FlagW[0] & ALUFlags[0]) | (sticky_q & ~sticky_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: a reference model pushes expected outputs per step, compared after settling.
module tb_cond_flag_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, sticky_clr;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
  logic       sticky_ovf;

  cond_flag_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .sticky_clr(sticky_clr),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .sticky_ovf(sticky_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] strb;   // {PCSrc, RegWrite, MemWrite, CondEx}
    logic [4:0] state;  // {Flags, sticky_ovf}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic [3:0] m_flags;
  logic       m_sticky;

  task automatic chk(input string tag, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b1 : (base ^ c[0]);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic cx;
    cx = model_cond(Cond, m_flags);
    e.strb  = {PCS & cx & en, RegW & cx & en, MemW & cx & en, cx};
    e.state = {m_flags, m_sticky};
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 5'd1, 5'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_strb"}, {1'b0, PCSrc, RegWrite, MemWrite, CondEx}, {1'b0, e.strb});
    chk({tag, "_flags"}, {Flags, sticky_ovf}, e.state);
  endtask

  // Drive one instruction at the falling edge, check its combinational view, then commit at the rising edge.
  task automatic step(input string tag, input logic [3:0] c, input logic [3:0] alu,
                      input logic [1:0] fw, input logic pcs, input logic rw, input logic mw,
                      input logic e, input logic clr);
    logic cx;
    @(negedge clk);
    Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
    en = e; sticky_clr = clr;
    exp_q.push_back(model_out());
    #1 compare(tag);
    @(posedge clk);
    cx = model_cond(c, m_flags);
`ifdef STICKY_OVF_EN
    if (e) m_sticky = (cx & fw[0] & alu[0]) | (m_sticky & ~clr);
`else
    m_sticky = 1'b0;
`endif
    if (e && cx && fw[1]) m_flags[3:2] = alu[3:2];
    if (e && cx && fw[0]) m_flags[1:0] = alu[1:0];
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; sticky_clr = 1'b0;
    m_flags = 4'b0000; m_sticky = 1'b0;
    #12;
    exp_q.push_back(model_out());
    #1 compare("rst_eq");
    Cond = 4'h1; en = 1'b1; RegW = 1'b1;
    exp_q.push_back(model_out());
    #1 compare("rst_ne");
    @(negedge clk) rst_n = 1'b1;

    step("set_z",    4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("eq_pass",  4'h0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("ne_fail",  4'h1, 4'b1011, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("hold",     4'hE, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("clr_all",  4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("cv_only",  4'hE, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ge_fail",  4'hA, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lt_pass",  4'hB, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("stall",    4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("post_stl", 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges must clear state immediately.
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_flags = 4'b0000; m_sticky = 1'b0;
    exp_q.push_back(model_out());
    #1 compare("async_rst");
    @(negedge clk) rst_n = 1'b1;

    step("ovf_set",  4'hE, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ovf_keep", 4'hE, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("set_win",  4'hE, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("clr_stl",  4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("clr_only", 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("ovf_gone", 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end
    step("final", 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    if (exp_q.size() != 0) chk("queue_empty", 5'(exp_q.size()), 5'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Condition/flag stage directly downstream of the `alu`. It captures the ALU status outputs {N, Z, CO, OVF} into an architectural flag register under per-group write enables. It evaluates the instruction's 4-bit condition field against the stored flags and gates the datapath's PC-source, register-write and memory-write strobes. It sits between the `alu` flag outputs and the register file / PC / data-memory write controls of the single-cycle processor.

## Interface
- `RESET_FLAGS`, 4'b0000: flag register value after reset, ordered {N,Z,C,V}.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: instruction-commit enable; 0 = stall, no state change.
- `Cond` input 4: instruction condition field.
- `ALUFlags` input 4: {N, Z, CO, OVF} from the `alu`, same cycle.
- `FlagW` input 2: [1] = write N,Z; [0] = write C,V.
- `PCS` input 1: decoder request to write the PC.
- `RegW` input 1: decoder request to write the register file.
- `MemW` input 1: decoder request to write data memory.
- `sticky_clr` input 1: clears the sticky overflow bit (see Configuration).
- `PCSrc` output 1: gated PC write.
- `RegWrite` output 1: gated register write.
- `MemWrite` output 1: gated memory write.
- `CondEx` output 1: condition passed (combinational).
- `Flags` output 4: stored {N,Z,C,V}.
- `sticky_ovf` output 1: sticky overflow indicator.

## Operation
- Condition decode, against stored `Flags` only, never against `ALUFlags`:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 1.
- Output gating:
  - `PCSrc` = PCS & CondEx & en.
  - `RegWrite` = RegW & CondEx & en.
  - `MemWrite` = MemW & CondEx & en.
- Flag update at rising edge, only when en & CondEx:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - The two groups are independent; a group with its FlagW bit at 0 holds its value.
- A failed condition (CondEx=0) suppresses all writes, including flags.
- `en`=0 freezes `Flags` and `sticky_ovf`, and forces all three gated strobes to 0.

## Timing
- Combinational path Cond/Flags/PCS/RegW/MemW/en -> gated strobes and CondEx; zero latency.
- Flags written in cycle k are visible on `Flags`, and used by the condition decode, from cycle k+1.
- A flag-setting instruction therefore evaluates its own condition on the pre-update flags.
- Reset (asynchronous, any time, including mid-instruction):
  - `Flags` = RESET_FLAGS and `sticky_ovf` = 0 immediately.
  - Gated strobes follow the combinational equations using the reset flags.
- Release of `rst_n` is synchronous to `clk`; first update occurs on the first edge with `rst_n`=1.
- Back-to-back flag writes every cycle are supported; no bubbles.

## Configuration
- `STICKY_OVF_EN` defined:
  - `sticky_ovf` sets at the edge where a committed write with FlagW[0]=1 loads V=1.
  - It stays set until `sticky_clr`=1 at an edge, or reset.
  - Simultaneous set and clear: set wins.
- `STICKY_OVF_EN` undefined: `sticky_ovf` tied to 0, `sticky_clr` ignored, no sticky flop.

## Test plan
- Reset with RESET_FLAGS=4'b0000 -> Flags=0000; Cond=0000 gives CondEx=0; Cond=0001 gives CondEx=1.
- Cond=1110, FlagW=11, ALUFlags=0100, en=1, edge -> Flags=0100. Next cycle: Cond=0000 gives CondEx=1 and RegW=1 gives RegWrite=1.
- Flags=0100, Cond=0001 (fails), FlagW=11, ALUFlags=1011, RegW=MemW=PCS=1 -> all strobes 0; after edge Flags still 0100.
- FlagW=01, ALUFlags=1111 from Flags=0000 -> Flags=0011 (N,Z held). Then Cond=1010 gives CondEx=0 and Cond=1011 gives CondEx=1.
- en=0 with Cond=1110, FlagW=11, ALUFlags=1111 -> strobes 0, Flags unchanged. Assert rst_n=0 mid-cycle -> Flags=RESET_FLAGS without waiting for a clock edge.
- With STICKY_OVF_EN: commit FlagW=01, ALUFlags=0001 -> sticky_ovf=1. Then commit ALUFlags=0000 -> sticky_ovf still 1. Then sticky_clr=1 with a new V=1 commit in the same cycle -> sticky_ovf stays 1. Then sticky_clr alone -> sticky_ovf=0. Without the macro, sticky_ovf=0 throughout.
